// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file geometry and operand types
package cpu_pkg;
  localparam int NREGS = 64;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CTRL_W = 8;
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight bits, set beats both clears
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_rd,
  input  logic      clr_a_en,
  input  reg_addr_t clr_a_rd,
  input  logic      clr_b_en,
  input  reg_addr_t clr_b_rd,
  input  reg_addr_t look_a,
  input  reg_addr_t look_b,
  input  reg_addr_t look_c,
  output logic      busy_a,
  output logic      busy_b,
  output logic      busy_c
);
  logic [NREGS-1:0] busy, set_mask, clr_mask;
  always_comb begin
    set_mask = set_en ? NREGS'(1) << set_rd : '0;
    clr_mask = (clr_a_en ? NREGS'(1) << clr_a_rd : '0) | (clr_b_en ? NREGS'(1) << clr_b_rd : '0);
  end
  always_ff @(posedge clk)
    if (rst) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
  assign busy_a = busy[look_a];
  assign busy_b = busy[look_b];
  assign busy_c = busy[look_c];
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads operands with writeback bypass, stalls on RAW/WAW, one-entry output register
module operand_fetch_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  reg_addr_t         in_rs,
  input  reg_addr_t         in_rt,
  input  reg_addr_t         in_rd,
  input  logic              in_writes_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output reg_addr_t         rf_rs,
  output reg_addr_t         rf_rt,
  input  word_t             rf_rs_data,
  input  word_t             rf_rt_data,
  input  logic              wb_en,
  input  reg_addr_t         wb_rd,
  input  word_t             wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output word_t             out_rs_data,
  output word_t             out_rt_data,
  output reg_addr_t         out_rd,
  output logic              out_writes_rd,
  output logic [CTRL_W-1:0] out_ctrl
);
  logic busy_rs, busy_rt, busy_rd, wbclr_rs, wbclr_rt, wbclr_rd, hz, accept;
  assign rf_rs = in_rs;
  assign rf_rt = in_rt;
  always_comb begin
    wbclr_rs = wb_en && wb_rd == in_rs;
    wbclr_rt = wb_en && wb_rd == in_rt;
    wbclr_rd = wb_en && wb_rd == in_rd;
    hz = (busy_rs && !wbclr_rs) || (busy_rt && !wbclr_rt) || (in_writes_rd && busy_rd && !wbclr_rd);
    in_ready = !rst && !flush && !hz && (!out_valid || out_ready);
    accept = in_valid && in_ready;
  end
  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && in_writes_rd),
    .set_rd   (in_rd),
    .clr_a_en (wb_en),
    .clr_a_rd (wb_rd),
    .clr_b_en (flush && out_valid && out_writes_rd),
    .clr_b_rd (out_rd),
    .look_a   (in_rs),
    .look_b   (in_rt),
    .look_c   (in_rd),
    .busy_a   (busy_rs),
    .busy_b   (busy_rt),
    .busy_c   (busy_rd)
  );
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_rd <= '0;
      out_writes_rd <= 1'b0;
      out_ctrl <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_rs_data <= wbclr_rs ? wb_data : rf_rs_data;
      out_rt_data <= wbclr_rt ? wb_data : rf_rt_data;
      out_rd <= in_rd;
      out_writes_rd <= in_writes_rd;
      out_ctrl <= in_ctrl;
    end else if (flush || out_ready) out_valid <= 1'b0;
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute stage sitting directly downstream of the 64x32 register file.
- Drives the register file read addresses and captures rs/rt operands, bypassing same-cycle writeback data.
- Tracks in-flight destination registers in a 64-bit scoreboard and stalls on RAW/WAW hazards.
- Hands operands to the ALU stage through a one-entry valid/ready output register; a taken branch flushes that register.

Parameters:
- NREGS, 64, number of architectural registers.
- AW, 6, register address width.
- DW, 32, data width.
- CTRL_W, 8, width of the opaque decoded-control bundle passed through to execute.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs  in  AW  source register 1.
- in_rt  in  AW  source register 2.
- in_rd  in  AW  destination register.
- in_writes_rd  in  1  instruction writes rd.
- in_ctrl  in  CTRL_W  decoded control, passed through unchanged.
- rf_rs  out  AW  register file read address 1; equals in_rs combinationally.
- rf_rt  out  AW  register file read address 2; equals in_rt combinationally.
- rf_rs_data  in  DW  register file read data 1, combinational.
- rf_rt_data  in  DW  register file read data 2, combinational.
- wb_en  in  1  writeback strobe; the same signal drives register file regWrite.
- wb_rd  in  AW  writeback destination.
- wb_data  in  DW  writeback data.
- flush  in  1  kill the output entry and block acceptance this cycle.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute accepts.
- out_rs_data  out  DW  captured operand 1.
- out_rt_data  out  DW  captured operand 2.
- out_rd  out  AW  destination register.
- out_writes_rd  out  1  destination write flag.
- out_ctrl  out  CTRL_W  control bundle.

Behaviour:
- Reset:
  - out_valid=0; all out_* data fields=0; busy[NREGS-1:0]=0.
  - in_ready=0 while rst=1.
- Retiring writeback: wbclr(x) = wb_en && wb_rd==x.
- Hazard:
  - hz = (busy[in_rs] && !wbclr(in_rs)) || (busy[in_rt] && !wbclr(in_rt)) || (in_writes_rd && busy[in_rd] && !wbclr(in_rd)).
  - Hazard checks apply uniformly to all NREGS registers; register 0 is not special.
- Ready and accept:
  - in_ready = !rst && !flush && !hz && (!out_valid || out_ready).
  - accept = in_valid && in_ready.
- Operand capture on accept:
  - out_rs_data <= wbclr(in_rs) ? wb_data : rf_rs_data. Same rule for rt.
  - The bypass covers the register file writing on the same edge.
  - rs==rt is legal; both outputs get the same value.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1. Back-to-back independent instructions sustain one per cycle.
- Output register:
  - Holds all out_* stable while out_valid && !out_ready.
  - Clears out_valid when out_ready=1 and nothing is accepted.
- Scoreboard, per bit x per cycle, in priority order:
  - set if accept && in_writes_rd && in_rd==x;
  - else clear if wbclr(x);
  - else clear if flush && out_valid && out_writes_rd && out_rd==x;
  - else hold.
  - Set beats same-cycle clear, so a reissued writer of a retiring register ends busy.
  - WAW stall guarantees at most one in-flight writer per register, so one bit per register is enough.
- Flush:
  - out_valid <= 0 next cycle and no accept this cycle.
  - Releases the killed entry's busy bit.
  - Older instructions already in execute and later stages still retire and clear their bits through wb.
- Simultaneous out_ready && flush: flush wins; execute must not consume the entry.
- Reset mid-operation wipes the scoreboard. Upstream and downstream stages reset on the same edge.

Decomposition:
- Package cpu_pkg:
  - AW, DW, NREGS, CTRL_W constants.
  - Typedef reg_addr_t = logic [AW-1:0].
  - Typedef word_t = logic [DW-1:0].
- Sub-module reg_scoreboard:
  - 64-bit busy vector with one set port and two clear ports, using the priority above.
  - Three combinational busy-lookup ports.

Test Plan:
- Reset then issue ADD rs=1, rt=2, rd=6 with regfile x1=2, x2=5 -> next cycle out_valid=1, out_rs_data=2, out_rt_data=5, busy[6]=1.
- Next instruction reads rs=6 while x6 in flight -> in_ready=0 each cycle; when wb_en=1, wb_rd=6, wb_data=7 -> accepted that cycle, out_rs_data=7 from bypass, busy[6]=0.
- WAW: in-flight writer of x3, new instruction rd=3 rs=0 rt=0 -> stalls until wb_rd=3 retires; on the accept cycle busy[3] stays 1 (set beats clear).
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> next instruction accepted the same cycle.
- Flush with valid output entry rd=10 and out_ready=1 -> out_valid=0 next cycle, busy[10]=0, no accept that cycle.
- Assert rst for one cycle with busy[7]=1 and out_valid=1 -> next cycle out_valid=0, busy=0, in_ready=1 for an independent instruction.
